hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameters SHALL be, one per line:
  RAW, 5, register address width
  LOAD_LAT, 1, data-memory load-use bubbles, legal 1..8
  MUL_LAT, 4, multi-cycle mul/div execute cycles, legal 2..32
  CNT_W, 16, stall performance counter width
REQ-002 Ports SHALL be, one per line:
  clk_i  in  1  single clock, all state on rising edge
  rst_i  in  1  synchronous reset, active-high
  ID_rs1_i  in  RAW  ID-stage source register 1
  ID_rs2_i  in  RAW  ID-stage source register 2
  ID_rs1_used_i  in  1  ID instruction reads rs1
  ID_rs2_used_i  in  1  ID instruction reads rs2
  EX_MemRead_i  in  1  EX instruction is a load
  EX_rd_i  in  RAW  EX destination register
  EX_MulDiv_i  in  1  EX instruction is multi-cycle mul/div
  EX_Branch_taken_i  in  1  EX resolved taken branch/jump
  Noop_o  out  1  insert bubble into ID/EX
  Stall_o  out  1  hold IF/ID register
  PCWrite_o  out  1  PC update enable
  Flush_o  out  1  clear IF/ID to bubble
  EX_hold_o  out  1  hold ID/EX and EX state
  Stall_count_o  out  CNT_W  saturating count of stalled cycles
REQ-003 Clocking SHALL be exactly: one clock; reset is synchronous and active-high.

Function
REQ-004 Controller SHALL be an FSM with states IDLE, LOAD_WAIT and MUL_BUSY, plus a down-counter wide enough for max(LOAD_LAT,MUL_LAT)-1.
REQ-005 Load-use hit SHALL be EX_MemRead_i & (EX_rd_i != 0) & ((ID_rs1_used_i & rs1 == EX_rd_i) | (ID_rs2_used_i & rs2 == EX_rd_i)).
  - x0 and unused operands never cause a hit.
REQ-006 In IDLE on a load-use hit, outputs SHALL combinationally be Noop_o=1, Stall_o=1, PCWrite_o=0 in that cycle.
  - If LOAD_LAT>1: next state LOAD_WAIT, counter=LOAD_LAT-2.
  - Otherwise: remain IDLE.
  - Total stall is exactly LOAD_LAT cycles.
REQ-007 In LOAD_WAIT: Noop_o=1, Stall_o=1, PCWrite_o=0; counter decrements each cycle; state returns to IDLE on the cycle after the counter reaches 0.
REQ-008 In IDLE with EX_MulDiv_i=1: Stall_o=1, PCWrite_o=0, EX_hold_o=1, Noop_o=0 combinationally; next state MUL_BUSY, counter=MUL_LAT-2.
REQ-009 In MUL_BUSY: Stall_o=1, PCWrite_o=0, EX_hold_o=1, Noop_o=0.
  - On counter==0, that cycle is the last hold; next state IDLE.
  - Total hold is exactly MUL_LAT cycles.
  - EX_MulDiv_i is ignored while MUL_BUSY (no restart).
REQ-010 In IDLE with EX_Branch_taken_i=1: Flush_o=1 and Noop_o=1 for that cycle; PCWrite_o=1; Stall_o=0.
  - A branch suppresses a simultaneous load-use hit: no stall, no LOAD_WAIT entry.
REQ-011 In IDLE, priority SHALL be EX_MulDiv_i > EX_Branch_taken_i > load-use.
  - EX_Branch_taken_i and EX_MulDiv_i are mutually exclusive by decode; if both are high, mul/div wins and Flush_o=0.
REQ-012 EX_Branch_taken_i SHALL be ignored in LOAD_WAIT and MUL_BUSY; Flush_o=0 in those states.
REQ-013 In IDLE with no event: Noop_o=0, Stall_o=0, PCWrite_o=1, Flush_o=0, EX_hold_o=0.
REQ-014 Stall_count_o SHALL increment by 1 on every clock edge where Stall_o=1, and saturate at 2^CNT_W-1 (no wrap).
REQ-015 Outputs SHALL be combinational from state, counter and inputs; no extra output register latency.

Reset
REQ-016 While rst_i=1, outputs SHALL be forced to Noop_o=0, Stall_o=0, PCWrite_o=1, Flush_o=0, EX_hold_o=0, regardless of other inputs.
REQ-017 A clock edge with rst_i=1 SHALL set state=IDLE, counter=0 and Stall_count_o=0, including mid-LOAD_WAIT or mid-MUL_BUSY (operation aborted, no resumption).
REQ-018 On the first cycle after rst_i falls, the block SHALL evaluate hazards normally from IDLE.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
  - LOAD_LAT=3, EX load rd=5, ID rs2=5 used -> Stall_o=Noop_o=1, PCWrite_o=0 for exactly 3 cycles, then 0/0/1; Stall_count_o=3.
  - EX load rd=0, ID rs1=0 used; then rd=7 with rs1=7 and ID_rs1_used_i=0 -> no stall in either case.
  - MUL_LAT=4, EX_MulDiv_i pulse -> EX_hold_o=Stall_o=1, Noop_o=0 for exactly 4 cycles; a second EX_MulDiv_i inside the window does not extend it.
  - Taken branch and load-use hit in the same IDLE cycle -> Flush_o=1, Noop_o=1, Stall_o=0, PCWrite_o=1, no LOAD_WAIT.
  - rst_i=1 in 2nd cycle of MUL_BUSY -> outputs go to defaults immediately; after the edge, state IDLE and Stall_count_o=0.
  - CNT_W=4, continuous load-use hits for 20 cycles -> Stall_count_o saturates at 15.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle mul/div holds and
// taken-branch flushes, plus a saturating count of stalled cycles.
module hazard_control_unit #(
    parameter int RAW      = 5,
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [RAW-1:0]   ID_rs1_i,
    input  logic [RAW-1:0]   ID_rs2_i,
    input  logic             ID_rs1_used_i,
    input  logic             ID_rs2_used_i,
    input  logic             EX_MemRead_i,
    input  logic [RAW-1:0]   EX_rd_i,
    input  logic             EX_MulDiv_i,
    input  logic             EX_Branch_taken_i,
    output logic             Noop_o,
    output logic             Stall_o,
    output logic             PCWrite_o,
    output logic             Flush_o,
    output logic             EX_hold_o,
    output logic [CNT_W-1:0] Stall_count_o
);

    localparam int MAX_LAT = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
    localparam int CW      = $clog2(MAX_LAT);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD_WAIT = 2'd1;
    localparam logic [1:0] MUL_BUSY  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             load_use_hit;

    // x0 is hardwired zero, and an operand the ID instruction does not read
    // cannot depend on the load.
    assign load_use_hit = EX_MemRead_i && (EX_rd_i != '0) &&
                          ((ID_rs1_used_i && (ID_rs1_i == EX_rd_i)) ||
                           (ID_rs2_used_i && (ID_rs2_i == EX_rd_i)));

    always_comb begin
        // NOTE: every output and next-state signal gets a default first so no
        // path through the case leaves one unassigned and infers a latch.
        Noop_o    = 1'b0;
        Stall_o   = 1'b0;
        PCWrite_o = 1'b1;
        Flush_o   = 1'b0;
        EX_hold_o = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;

        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (EX_MulDiv_i) begin
                        Stall_o   = 1'b1;
                        PCWrite_o = 1'b0;
                        EX_hold_o = 1'b1;
                        state_d   = MUL_BUSY;
                        cnt_d     = CW'(MUL_LAT - 2);
                    end else if (EX_Branch_taken_i) begin
                        // The flush already kills the dependent instruction,
                        // so a coincident load-use hit needs no stall.
                        Flush_o = 1'b1;
                        Noop_o  = 1'b1;
                    end else if (load_use_hit) begin
                        Noop_o    = 1'b1;
                        Stall_o   = 1'b1;
                        PCWrite_o = 1'b0;
                        if (LOAD_LAT > 1) begin
                            state_d = LOAD_WAIT;
                            cnt_d   = CW'(LOAD_LAT - 2);
                        end
                    end
                end
                LOAD_WAIT: begin
                    Noop_o    = 1'b1;
                    Stall_o   = 1'b1;
                    PCWrite_o = 1'b0;
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - CW'(1);
                end
                MUL_BUSY: begin
                    Stall_o   = 1'b1;
                    PCWrite_o = 1'b0;
                    EX_hold_o = 1'b1;
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - CW'(1);
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (Stall_o && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign Stall_count_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: per-cycle vector table applied
// through an expected-value queue, plus a saturation sequence.
module tb_hazard_control_unit;

    localparam int RAW = 5;
    localparam int CW  = 4;

    // {Noop, Stall, PCWrite, Flush, EX_hold}
    localparam logic [4:0] NRM = 5'b00100;
    localparam logic [4:0] LST = 5'b11000;
    localparam logic [4:0] MUL = 5'b01001;
    localparam logic [4:0] BRF = 5'b10110;

    typedef struct {
        logic           rst;
        logic [RAW-1:0] rs1;
        logic [RAW-1:0] rs2;
        logic           u1;
        logic           u2;
        logic           mr;
        logic [RAW-1:0] rd;
        logic           md;
        logic           br;
        logic [4:0]     ctl;
        logic [CW-1:0]  cnt;
    } vec_t;

    typedef struct {
        logic [4:0]    ctl;
        logic [CW-1:0] cnt;
        string         tag;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [RAW-1:0] id_rs1, id_rs2, ex_rd;
    logic           id_rs1_used, id_rs2_used, ex_mem_read, ex_mul_div, ex_br;
    logic           noop, stall, pc_write, flush, ex_hold;
    logic [CW-1:0]  stall_count;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(
        .RAW(RAW),
        .LOAD_LAT(3),
        .MUL_LAT(4),
        .CNT_W(CW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .ID_rs1_i(id_rs1),
        .ID_rs2_i(id_rs2),
        .ID_rs1_used_i(id_rs1_used),
        .ID_rs2_used_i(id_rs2_used),
        .EX_MemRead_i(ex_mem_read),
        .EX_rd_i(ex_rd),
        .EX_MulDiv_i(ex_mul_div),
        .EX_Branch_taken_i(ex_br),
        .Noop_o(noop),
        .Stall_o(stall),
        .PCWrite_o(pc_write),
        .Flush_o(flush),
        .EX_hold_o(ex_hold),
        .Stall_count_o(stall_count)
    );

    function automatic void add(input logic r, input logic [RAW-1:0] s1, input logic [RAW-1:0] s2,
                                input logic a1, input logic a2, input logic m, input logic [RAW-1:0] d,
                                input logic mdv, input logic b, input logic [4:0] c, input logic [CW-1:0] n);
        vec_t v;
        v.rst = r; v.rs1 = s1; v.rs2 = s2; v.u1 = a1; v.u2 = a2;
        v.mr = m; v.rd = d; v.md = mdv; v.br = b; v.ctl = c; v.cnt = n;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    // Drive one cycle's inputs after the falling edge, queue the expectation,
    // then compare the settled combinational outputs well before the next rise.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        rst = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2;
        id_rs1_used = v.u1; id_rs2_used = v.u2;
        ex_mem_read = v.mr; ex_rd = v.rd; ex_mul_div = v.md; ex_br = v.br;
        e.ctl = v.ctl; e.cnt = v.cnt; e.tag = tag;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        check({e.tag, "_ctl"}, {27'd0, noop, stall, pc_write, flush, ex_hold}, {27'd0, e.ctl});
        check({e.tag, "_cnt"}, {28'd0, stall_count}, {28'd0, e.cnt});
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_mem_read = 1'b0; ex_rd = '0; ex_mul_div = 1'b0; ex_br = 1'b0;
        repeat (2) @(posedge clk);

        //   rst rs1 rs2 u1 u2 mr rd md br  ctl  cnt
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0);   // reset state
        add(1, 0, 5, 0, 1, 1, 5, 1, 1, NRM, 0);   // reset overrides events
        add(0, 0, 5, 0, 1, 1, 5, 0, 0, LST, 0);   // load-use on rs2
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, LST, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, LST, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 3);   // exactly three stalls
        add(0, 0, 0, 1, 0, 1, 0, 0, 0, NRM, 3);   // rd = x0
        add(0, 7, 3, 0, 1, 1, 7, 0, 0, NRM, 3);   // match on unused rs1
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, MUL, 3);   // mul/div issue
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, MUL, 4);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1, MUL, 5);   // re-trigger and branch ignored
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, MUL, 6);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 7);   // hold lasted exactly four
        add(0, 5, 0, 1, 0, 1, 5, 0, 1, BRF, 7);   // branch beats load-use
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 7);   // no LOAD_WAIT entered
        add(0, 0, 0, 0, 0, 0, 0, 1, 1, MUL, 7);   // mul/div beats branch
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, MUL, 8);   // first MUL_BUSY cycle
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 9);   // reset in second MUL_BUSY cycle
        add(0, 0, 5, 0, 1, 1, 5, 0, 0, LST, 0);   // first cycle after reset: from IDLE
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 1);   // reset aborts LOAD_WAIT
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0);   // no resumption

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Continuous load-use hits: the counter must stop at 15.
        add(0, 4, 0, 1, 0, 1, 4, 0, 0, LST, 0);
        v = vecs[vecs.size()-1];
        for (int k = 0; k < 20; k++) begin
            v.cnt = (k > 15) ? CW'(15) : CW'(k);
            apply(v, $sformatf("sat%0d", k));
        end
        v = vecs[0];
        v.rst = 1'b0; v.ctl = LST; v.cnt = 4'd15;
        apply(v, "sat_tail");                     // last LOAD_WAIT cycle
        v.ctl = NRM;
        apply(v, "sat_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
